// File: rtl/onehot_mon_pkg.sv
// Shared constants and types for the one-hot detector run monitor.
package onehot_mon_pkg;

  localparam logic POL_ZERO = 1'b0;
  localparam logic POL_ONE  = 1'b1;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned LEN_W_DEF = 8;

  typedef struct packed {
    logic [LEN_W_DEF-1:0] len;
    logic                 pol;
  } run_evt_t;

endpackage

// File: rtl/onehot_run_monitor_if.sv
// Sampled detector signals, statistics and the completed-run event handshake.
interface onehot_run_monitor_if
  import onehot_mon_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
);

  logic             z;
  logic             w;
  logic             clr;
  logic             evt_ack;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] zero_cnt;
  logic [CNT_W-1:0] one_cnt;
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W-1:0] max_len;
  logic             evt_valid;
  logic [LEN_W-1:0] evt_len;
  logic             evt_pol;
  logic             evt_ovf;

  modport master (
    output z, w, clr, evt_ack,
    input  run_cnt, zero_cnt, one_cnt, cur_len, max_len,
    input  evt_valid, evt_len, evt_pol, evt_ovf
  );

  modport slave (
    input  z, w, clr, evt_ack,
    output run_cnt, zero_cnt, one_cnt, cur_len, max_len,
    output evt_valid, evt_len, evt_pol, evt_ovf
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         load1,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;

  // clr beats load1 beats inc
  always_comb begin
    q_d = q;
    if (clr) begin
      q_d = '0;
    end else if (load1) begin
      q_d = W'(1);
    end else if (inc && (q != '1)) begin
      q_d = q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/onehot_run_monitor.sv
// Measures runs of z-high cycles and reports each finished run as a valid/ack event.
// Optional max-length tracking is built when RUN_MAX_TRACK_EN is defined.
module onehot_run_monitor
  import onehot_mon_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  onehot_run_monitor_if.slave bus
);

  logic             z_q, w_q, pol_r;
  logic             run_start, run_cont, run_end;
  logic [CNT_W-1:0] run_cnt, zero_cnt, one_cnt;
  logic [LEN_W-1:0] cur_len;
  logic             evt_valid_q, evt_valid_d;
  logic [LEN_W-1:0] evt_len_q, evt_len_d;
  logic             evt_pol_q, evt_pol_d;
  logic             evt_ovf_q, evt_ovf_d;

  assign run_start = bus.z & ~z_q;
  assign run_cont  = bus.z & z_q;
  assign run_end   = ~bus.z & z_q;

  // w_q at a run start is the input that moved the detector into its detecting state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z_q   <= 1'b0;
      w_q   <= 1'b0;
      pol_r <= 1'b0;
    end else begin
      z_q <= bus.z;
      w_q <= bus.w;
      if (run_start) pol_r <= w_q;
    end
  end

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk(clk), .rst(rst), .clr(bus.clr), .inc(run_start), .load1(1'b0), .q(run_cnt)
  );
  sat_counter #(.W(CNT_W)) u_zero_cnt (
    .clk(clk), .rst(rst), .clr(bus.clr), .inc(run_start && (w_q == POL_ZERO)), .load1(1'b0),
    .q(zero_cnt)
  );
  sat_counter #(.W(CNT_W)) u_one_cnt (
    .clk(clk), .rst(rst), .clr(bus.clr), .inc(run_start && (w_q == POL_ONE)), .load1(1'b0),
    .q(one_cnt)
  );
  // Run length ignores the statistics clear so a run in progress keeps being measured
  sat_counter #(.W(LEN_W)) u_cur_len (
    .clk(clk), .rst(rst), .clr(run_end), .inc(run_cont), .load1(run_start), .q(cur_len)
  );

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_len_d   = evt_len_q;
    evt_pol_d   = evt_pol_q;
    evt_ovf_d   = evt_ovf_q;
    if (bus.clr) begin
      evt_valid_d = 1'b0;
      evt_len_d   = '0;
      evt_pol_d   = 1'b0;
      evt_ovf_d   = 1'b0;
    end else if (run_end) begin
      if (!evt_valid_q || bus.evt_ack) begin
        evt_valid_d = 1'b1;
        evt_len_d   = cur_len;
        evt_pol_d   = pol_r;
      end else begin
        evt_ovf_d = 1'b1;
      end
    end else if (bus.evt_ack) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid_q <= 1'b0;
      evt_len_q   <= '0;
      evt_pol_q   <= 1'b0;
      evt_ovf_q   <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_len_q   <= evt_len_d;
      evt_pol_q   <= evt_pol_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

`ifdef RUN_MAX_TRACK_EN
  logic [LEN_W-1:0] max_len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_len_q <= '0;
    end else if (bus.clr) begin
      max_len_q <= '0;
    end else if (run_end && (cur_len > max_len_q)) begin
      max_len_q <= cur_len;
    end
  end

  assign bus.max_len = max_len_q;
`else
  assign bus.max_len = '0;
`endif

  assign bus.run_cnt   = run_cnt;
  assign bus.zero_cnt  = zero_cnt;
  assign bus.one_cnt   = one_cnt;
  assign bus.cur_len   = cur_len;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_len   = evt_len_q;
  assign bus.evt_pol   = evt_pol_q;
  assign bus.evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_onehot_run_monitor.sv
// Scoreboard bench for onehot_run_monitor: default widths plus LEN_W=4 and CNT_W=2 copies.
module tb_onehot_run_monitor;
  import onehot_mon_pkg::*;

`ifdef RUN_MAX_TRACK_EN
  localparam bit MaxEn = 1'b1;
`else
  localparam bit MaxEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic z = 1'b0, w = 1'b0, clr = 1'b0, evt_ack = 1'b0;

  always #5 clk = ~clk;

  onehot_run_monitor_if #(.CNT_W(8), .LEN_W(8)) bus_a ();
  onehot_run_monitor_if #(.CNT_W(8), .LEN_W(4)) bus_l ();
  onehot_run_monitor_if #(.CNT_W(2), .LEN_W(8)) bus_c ();

  assign bus_a.z = z;  assign bus_a.w = w;  assign bus_a.clr = clr;  assign bus_a.evt_ack = evt_ack;
  assign bus_l.z = z;  assign bus_l.w = w;  assign bus_l.clr = clr;  assign bus_l.evt_ack = evt_ack;
  assign bus_c.z = z;  assign bus_c.w = w;  assign bus_c.clr = clr;  assign bus_c.evt_ack = evt_ack;

  onehot_run_monitor #(.CNT_W(8), .LEN_W(8)) u_dut  (.clk(clk), .rst(rst), .bus(bus_a));
  onehot_run_monitor #(.CNT_W(8), .LEN_W(4)) u_len4 (.clk(clk), .rst(rst), .bus(bus_l));
  onehot_run_monitor #(.CNT_W(2), .LEN_W(8)) u_cnt2 (.clk(clk), .rst(rst), .bus(bus_c));

  int n_checks = 0;
  int n_errors = 0;
  run_evt_t sb_q[$];

  // Bench-side detector: z high while the last two w samples match
  logic h1 = 1'b0, h2 = 1'b0;
  int   hv = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic zv, input logic wv);
    z = zv;
    w = wv;
    @(posedge clk);
    #1;
  endtask

  task automatic det(input logic wv);
    step((hv >= 2) && (h1 == h2), wv);
    h2 = h1;
    h1 = wv;
    hv++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    z = 1'b0;
    w = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    h1 = 1'b0;
    h2 = 1'b0;
    hv = 0;
  endtask

  task automatic expect_evt(input int len, input logic pol);
    run_evt_t e;
    e.len = 8'(len);
    e.pol = pol;
    sb_q.push_back(e);
  endtask

  task automatic check_evt(input string tag);
    run_evt_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got len %0d expected an entry", tag, bus_a.evt_len);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, "_valid"}, bus_a.evt_valid, 1);
      check_eq({tag, "_len"}, bus_a.evt_len, e.len);
      check_eq({tag, "_pol"}, bus_a.evt_pol, e.pol);
    end
  endtask

  task automatic run_begin(input logic pol);
    step(1'b0, pol);
  endtask

  task automatic run_hold(input int n, input logic pol);
    repeat (n) step(1'b1, pol);
  endtask

  task automatic run_end(input logic wnext, input logic ack);
    evt_ack = ack;
    step(1'b0, wnext);
    evt_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step(1'b0, 1'b0);
    clr = 1'b0;
  endtask

  task automatic pulse_ack();
    evt_ack = 1'b1;
    step(1'b0, 1'b0);
    evt_ack = 1'b0;
  endtask

  task automatic check_stats_zero(input string tag);
    check_eq({tag, "_run_cnt"}, bus_a.run_cnt, 0);
    check_eq({tag, "_zero_cnt"}, bus_a.zero_cnt, 0);
    check_eq({tag, "_one_cnt"}, bus_a.one_cnt, 0);
    check_eq({tag, "_max_len"}, bus_a.max_len, 0);
    check_eq({tag, "_evt_valid"}, bus_a.evt_valid, 0);
    check_eq({tag, "_evt_len"}, bus_a.evt_len, 0);
    check_eq({tag, "_evt_pol"}, bus_a.evt_pol, 0);
    check_eq({tag, "_evt_ovf"}, bus_a.evt_ovf, 0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_stats_zero("reset");
    check_eq("reset_cur_len", bus_a.cur_len, 0);

    // Two-zeros run from w = 0,0,0,0,1
    det(1'b0); det(1'b0); det(1'b0);
    check_eq("t1_start_run_cnt", bus_a.run_cnt, 1);
    check_eq("t1_start_cur_len", bus_a.cur_len, 1);
    det(1'b0); det(1'b1);
    check_eq("t1_cur_len3", bus_a.cur_len, 3);
    expect_evt(3, POL_ZERO);
    det(1'b0);
    check_evt("t1_evt");
    check_eq("t1_run_cnt", bus_a.run_cnt, 1);
    check_eq("t1_zero_cnt", bus_a.zero_cnt, 1);
    check_eq("t1_one_cnt", bus_a.one_cnt, 0);
    check_eq("t1_cur_len0", bus_a.cur_len, 0);
    check_eq("t1_ovf", bus_a.evt_ovf, 0);

    // Ones run of 2 then zeros run of 4
    do_reset();
    det(1'b1); det(1'b1); det(1'b1); det(1'b0);
    expect_evt(2, POL_ONE);
    det(1'b1);
    check_evt("t2_ones_evt");
    det(1'b0); det(1'b0); det(1'b0); det(1'b0); det(1'b0); det(1'b1);
    check_eq("t2_cur_len4", bus_a.cur_len, 4);
    expect_evt(2, POL_ONE);
    det(1'b0);
    check_evt("t2_zeros_dropped");
    check_eq("t2_one_cnt", bus_a.one_cnt, 1);
    check_eq("t2_zero_cnt", bus_a.zero_cnt, 1);
    check_eq("t2_run_cnt", bus_a.run_cnt, 2);
    check_eq("t2_max_len", bus_a.max_len, MaxEn ? 4 : 0);
    check_eq("t2_ovf", bus_a.evt_ovf, 1);

    pulse_clr();
    check_stats_zero("clr_idle");

    // Overflow: two runs, no ack
    run_begin(1'b0);
    run_hold(2, 1'b0);
    expect_evt(2, POL_ZERO);
    run_end(1'b1, 1'b0);
    check_evt("t3_first");
    run_begin(1'b1);
    run_hold(1, 1'b1);
    expect_evt(2, POL_ZERO);
    run_end(1'b0, 1'b0);
    check_evt("t3_retained");
    check_eq("t3_ovf_set", bus_a.evt_ovf, 1);
    pulse_ack();
    check_eq("t3_valid_cleared", bus_a.evt_valid, 0);
    check_eq("t3_ovf_sticky", bus_a.evt_ovf, 1);
    pulse_ack();
    check_eq("t3_ack_idle_valid", bus_a.evt_valid, 0);
    pulse_clr();
    check_eq("t3_ovf_clr", bus_a.evt_ovf, 0);

    // Ack coincident with a new run end
    run_begin(1'b1);
    run_hold(3, 1'b1);
    expect_evt(3, POL_ONE);
    run_end(1'b0, 1'b0);
    check_evt("t4_first");
    run_begin(1'b0);
    run_hold(5, 1'b0);
    expect_evt(5, POL_ZERO);
    run_end(1'b0, 1'b1);
    check_evt("t4_ack_same_edge");
    check_eq("t4_ovf", bus_a.evt_ovf, 0);

    // Length saturation at LEN_W=4
    pulse_ack();
    run_begin(1'b1);
    run_hold(20, 1'b1);
    check_eq("t5_len4_cur_sat", bus_l.cur_len, 15);
    check_eq("t5_len8_cur", bus_a.cur_len, 20);
    expect_evt(20, POL_ONE);
    run_end(1'b0, 1'b0);
    check_evt("t5_len8_evt");
    check_eq("t5_len4_evt_len", bus_l.evt_len, 15);
    check_eq("t5_len4_evt_pol", bus_l.evt_pol, 1);

    // Five one-cycle runs, z toggling every cycle, CNT_W=2 saturation
    pulse_clr();
    run_begin(1'b0);
    for (int i = 0; i < 5; i++) begin
      run_hold(1, 1'(i % 2));
      expect_evt(1, 1'(i % 2));
      run_end(~1'(i % 2), 1'b1);
      check_evt($sformatf("t5_pulse%0d", i));
    end
    check_eq("t5_cnt2_run_cnt", bus_c.run_cnt, 3);
    check_eq("t5_cnt2_zero_cnt", bus_c.zero_cnt, 3);
    check_eq("t5_cnt2_one_cnt", bus_c.one_cnt, 2);
    check_eq("t5_run_cnt", bus_a.run_cnt, 5);
    check_eq("t5_zero_cnt", bus_a.zero_cnt, 3);
    check_eq("t5_one_cnt", bus_a.one_cnt, 2);
    check_eq("t5_max_len", bus_a.max_len, MaxEn ? 1 : 0);

    // clr in the middle of a 6-cycle run
    run_begin(1'b1);
    run_hold(3, 1'b1);
    clr = 1'b1;
    step(1'b1, 1'b1);
    clr = 1'b0;
    check_stats_zero("t6_clr_mid");
    check_eq("t6_cur_len_kept", bus_a.cur_len, 4);
    run_hold(2, 1'b1);
    expect_evt(6, POL_ONE);
    run_end(1'b0, 1'b0);
    check_evt("t6_evt");
    check_eq("t6_run_cnt", bus_a.run_cnt, 0);
    check_eq("t6_max_len", bus_a.max_len, MaxEn ? 6 : 0);

    // Asynchronous reset in the middle of a run
    run_begin(1'b0);
    run_hold(3, 1'b0);
    check_eq("t7_pre_cur_len", bus_a.cur_len, 3);
    #2;
    rst = 1'b0;
    z = 1'b0;
    #1;
    check_eq("t7_rst_cur_len", bus_a.cur_len, 0);
    check_eq("t7_rst_run_cnt", bus_a.run_cnt, 0);
    check_eq("t7_rst_zero_cnt", bus_a.zero_cnt, 0);
    check_eq("t7_rst_evt_valid", bus_a.evt_valid, 0);
    check_eq("t7_rst_evt_len", bus_a.evt_len, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("t7_no_evt", bus_a.evt_valid, 0);
    check_eq("t7_run_cnt_idle", bus_a.run_cnt, 0);
    step(1'b1, 1'b0);
    check_eq("t7_first_start", bus_a.run_cnt, 1);
    check_eq("t7_first_cur_len", bus_a.cur_len, 1);
    step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
